// File: rtl/alu_muldiv_seq_pkg.sv
// Shared definitions for the Hack ALU sequencer: ALU control words, FSM states, opcodes.
package alu_ctrl_defs;

  // Control word bit order is {zx, nx, zy, ny, f, no}
  localparam logic [5:0] ALU_CTL_ADD  = 6'b000010;
  localparam logic [5:0] ALU_CTL_SUB  = 6'b010011;
  localparam logic [5:0] ALU_CTL_ZERO = 6'b101010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

endpackage

// File: rtl/alu_muldiv_seq_alu.sv
// 16-bit Hack ALU; the sequencer only needs the data output.
module hack_alu #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [5:0]       ctl,
  output logic [WIDTH-1:0] out
);

  logic [WIDTH-1:0] x_z, x_n, y_z, y_n, f_out;

  always_comb begin
    x_z   = ctl[5] ? '0 : x;
    x_n   = ctl[4] ? ~x_z : x_z;
    y_z   = ctl[3] ? '0 : y;
    y_n   = ctl[2] ? ~y_z : y_z;
    f_out = ctl[1] ? (x_n + y_n) : (x_n & y_n);
    out   = ctl[0] ? ~f_out : f_out;
  end

endmodule

// File: rtl/alu_muldiv_seq.sv
// Unsigned 16-bit shift-add multiply / restoring divide built around one Hack ALU.
// ALU_MULDIV_EARLY_TERM_EN: MUL stops as soon as the remaining multiplier bits are zero.
module alu_muldiv_seq
  import alu_ctrl_defs::*;
#(
  parameter int WIDTH = 16,
  parameter int ITER  = WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(ITER);

  if (WIDTH != 16 || ITER != WIDTH) begin : g_bad_width
    $error("alu_muldiv_seq supports only WIDTH=16 and ITER=WIDTH");
  end

  state_t           state, state_nxt;
  logic             op_q;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] acc, mcand, mplier;
  logic [WIDTH-1:0] rem, quo, divisor;

  logic [WIDTH-1:0] alu_x, alu_y, alu_out;
  logic [5:0]       alu_ctl;
  logic [WIDTH-1:0] rsh, acc_nxt, rem_nxt, quo_nxt;
  logic             carry, sub_ok, early, finish;

  hack_alu #(.WIDTH(WIDTH)) u_alu (
    .x   (alu_x),
    .y   (alu_y),
    .ctl (alu_ctl),
    .out (alu_out)
  );

  // The bit shifted out of rem is the 17th bit of the partial remainder, so it forces a subtract
  always_comb begin
    rsh     = {rem[WIDTH-2:0], quo[WIDTH-1]};
    carry   = rem[WIDTH-1];
    sub_ok  = carry | (rsh >= divisor);
    alu_x   = '0;
    alu_y   = '0;
    alu_ctl = ALU_CTL_ZERO;
    if (state == RUN) begin
      if (op_q == OP_MUL) begin
        alu_x   = acc;
        alu_y   = mcand;
        alu_ctl = ALU_CTL_ADD;
      end else begin
        alu_x   = rsh;
        alu_y   = divisor;
        alu_ctl = ALU_CTL_SUB;
      end
    end
    acc_nxt = mplier[0] ? alu_out : acc;
    rem_nxt = sub_ok ? alu_out : rsh;
    quo_nxt = {quo[WIDTH-2:0], sub_ok};
`ifdef ALU_MULDIV_EARLY_TERM_EN
    early = (op_q == OP_MUL) && (mplier[WIDTH-1:1] == '0);
`else
    early = 1'b0;
`endif
    finish = (count == CW'(ITER - 1)) | early;
  end

  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) state_nxt = (op == OP_DIV && b == '0) ? DONE : RUN;
      end
      RUN:     if (finish) state_nxt = DONE;
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Result registers only change on entry to DONE; div_by_zero alone clears on accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q        <= OP_MUL;
      count       <= '0;
      acc         <= '0;
      mcand       <= '0;
      mplier      <= '0;
      rem         <= '0;
      quo         <= '0;
      divisor     <= '0;
      result      <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (state == IDLE && start) begin
      op_q        <= op;
      count       <= '0;
      divisor     <= b;
      div_by_zero <= 1'b0;
      if (op == OP_MUL) begin
        acc    <= '0;
        mcand  <= a;
        mplier <= b;
      end else if (b == '0) begin
        result      <= '1;
        remainder   <= a;
        div_by_zero <= 1'b1;
      end else begin
        rem <= '0;
        quo <= a;
      end
    end else if (state == RUN) begin
      count <= count + 1'b1;
      if (op_q == OP_MUL) begin
        acc    <= acc_nxt;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        if (finish) begin
          result    <= acc_nxt;
          remainder <= '0;
        end
      end else begin
        rem <= rem_nxt;
        quo <= quo_nxt;
        if (finish) begin
          result    <= quo_nxt;
          remainder <= rem_nxt;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Self-checking bench for alu_muldiv_seq: directed table, random ops vs. arithmetic model, corner sequences.
module tb_alu_muldiv_seq;
  import alu_ctrl_defs::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        op = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        ready, done, div_by_zero;
  logic [15:0] result, remainder;

  int          nVec = 0;
  int          nErr = 0;
  logic [15:0] lastRes = '0;

  typedef struct {
    logic        op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic [15:0] rem;
    logic        dbz;
  } vec_t;

  vec_t vecs[6];

  always #5 clk = ~clk;

  alu_muldiv_seq dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .op          (op),
    .a           (a),
    .b           (b),
    .ready       (ready),
    .done        (done),
    .result      (result),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Cycles from the accept cycle (cycle 0) to the cycle in which done is high
  function automatic int expLatency(input logic o, input logic [15:0] bv);
    int hi;
    hi = 0;
    if (o == OP_DIV) return (bv == 16'd0) ? 1 : 17;
`ifdef ALU_MULDIV_EARLY_TERM_EN
    for (int i = 0; i < 16; i++) if (bv[i]) hi = i;
    return hi + 2;
`else
    return 17 + hi;
`endif
  endfunction

  function automatic void refModel(input logic o, input logic [15:0] av, input logic [15:0] bv,
                                   output logic [15:0] res, output logic [15:0] rem,
                                   output logic dbz);
    logic [31:0] prod;
    prod = {16'd0, av} * {16'd0, bv};
    dbz  = 1'b0;
    if (o == OP_MUL) begin
      res = prod[15:0];
      rem = 16'd0;
    end else if (bv == 16'd0) begin
      res = 16'hFFFF;
      rem = av;
      dbz = 1'b1;
    end else begin
      res = av / bv;
      rem = av % bv;
    end
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nErr++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic o, input logic [15:0] av, input logic [15:0] bv,
                               input logic [15:0] expRes, input logic [15:0] expRem,
                               input logic expDbz);
    int cyc;
    @(negedge clk);
    checkOutput("ready_before", 32'(ready), 32'd1);
    start = 1'b1;
    op    = o;
    a     = av;
    b     = bv;
    @(posedge clk);
    #1;
    start = 1'b0;
    op    = 1'($urandom);
    a     = 16'($urandom);
    b     = 16'($urandom);
    cyc   = 1;
    if (!(o == OP_DIV && bv == 16'd0)) begin
      checkOutput("dbz_clear", 32'(div_by_zero), 32'd0);
      checkOutput("result_hold", 32'(result), 32'(lastRes));
    end
    while (!done && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    checkOutput("latency", 32'(cyc), 32'(expLatency(o, bv)));
    checkOutput("result", 32'(result), 32'(expRes));
    checkOutput("remainder", 32'(remainder), 32'(expRem));
    checkOutput("div_by_zero", 32'(div_by_zero), 32'(expDbz));
    lastRes = expRes;
    @(posedge clk);
    #1;
    checkOutput("done_one_cycle", 32'(done), 32'd0);
    checkOutput("ready_after", 32'(ready), 32'd1);
  endtask

  initial begin
    logic [15:0] rRes, rRem, av, bv;
    logic        rDbz, o;
    int          lat, doneCnt, readyCnt, firstDone, secondDone;
    logic        sawDone;

    vecs[0] = '{1'b0, 16'd300,   16'd7,     16'd2100,  16'd0,     1'b0};
    vecs[1] = '{1'b0, 16'hFFFF,  16'hFFFF,  16'h0001,  16'd0,     1'b0};
    vecs[2] = '{1'b1, 16'd1000,  16'd7,     16'd142,   16'd6,     1'b0};
    vecs[3] = '{1'b1, 16'hFFFF,  16'h8001,  16'd1,     16'h7FFE,  1'b0};
    vecs[4] = '{1'b1, 16'd42,    16'd0,     16'hFFFF,  16'd42,    1'b1};
    vecs[5] = '{1'b0, 16'h1234,  16'd0,     16'd0,     16'd0,     1'b0};

    #1;
    checkOutput("reset_ready", 32'(ready), 32'd1);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_result", 32'(result), 32'd0);
    checkOutput("reset_remainder", 32'(remainder), 32'd0);
    checkOutput("reset_dbz", 32'(div_by_zero), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++)
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].rem, vecs[i].dbz);

    for (int i = 0; i < 40; i++) begin
      o  = 1'($urandom);
      av = 16'($urandom);
      case ($urandom_range(0, 3))
        0:       bv = 16'($urandom_range(0, 15));
        1:       bv = 16'($urandom_range(0, 255));
        default: bv = 16'($urandom);
      endcase
      refModel(o, av, bv, rRes, rRem, rDbz);
      applyStimulus(o, av, bv, rRes, rRem, rDbz);
    end

    // start held high: back-to-back MULs, one accept per IDLE window
    lat = expLatency(OP_MUL, 16'd5);
    doneCnt = 0; readyCnt = 0; firstDone = 0; secondDone = 0;
    @(negedge clk);
    start = 1'b1; op = OP_MUL; a = 16'd3; b = 16'd5;
    @(posedge clk);
    #1;
    for (int c = 1; c <= 2 * lat + 1; c++) begin
      if (done) begin
        doneCnt++;
        if (doneCnt == 1) firstDone = c;
        else secondDone = c;
      end
      if (ready) readyCnt++;
      if (c == 2 * lat + 1) start = 1'b0;
      else begin
        @(posedge clk);
        #1;
      end
    end
    checkOutput("held_done_count", 32'(doneCnt), 32'd2);
    checkOutput("held_first_done", 32'(firstDone), 32'(lat));
    checkOutput("held_second_done", 32'(secondDone), 32'(2 * lat + 1));
    checkOutput("held_ready_windows", 32'(readyCnt), 32'd1);
    checkOutput("held_result", 32'(result), 32'd15);
    @(posedge clk);
    #1;
    checkOutput("held_ready_end", 32'(ready), 32'd1);
    lastRes = 16'd15;

    // reset asserted in the middle of a MUL
    @(negedge clk);
    start = 1'b1; op = OP_MUL; a = 16'd5; b = 16'd9;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_ready", 32'(ready), 32'd1);
    checkOutput("midrst_done", 32'(done), 32'd0);
    checkOutput("midrst_result", 32'(result), 32'd0);
    checkOutput("midrst_remainder", 32'(remainder), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    sawDone = 1'b0;
    repeat (25) begin
      @(posedge clk);
      #1;
      if (done) sawDone = 1'b1;
    end
    checkOutput("midrst_no_done", 32'(sawDone), 32'd0);
    lastRes = 16'd0;

    applyStimulus(OP_DIV, 16'd1000, 16'd7, 16'd142, 16'd6, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
